// File: rtl/jtcop_mcu_bridge.sv
// MCU side of the main-CPU/MCU "sec" mailbox: latches main commands for the MCU,
// commits MCU responses atomically to mcu_dout and pulses sec2 toward the main CPU.
module jtcop_mcu_bridge #(
  parameter int PULSE_LEN = 8
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [15:0] main_cmd,
  input  logic        main_wr,
  input  logic        main_rd,
  output logic [15:0] mcu_dout,
  output logic        sec2,
  input  logic [1:0]  mcu_addr,
  input  logic        mcu_wr,
  input  logic        mcu_rd,
  input  logic [7:0]  mcu_wdata,
  output logic [7:0]  mcu_rdata,
  output logic        mcu_intn
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} pulse_st_e;

  localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

  pulse_st_e   st, st_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        main_wr_l, main_rd_l;
  logic [15:0] cmd;
  logic [7:0]  resp_lo;
  logic        cmd_pend, ovr, resp_pend;
  logic        wr_fall, rd_fall;
  logic        commit, rd_hi, rd_st, clr_wr;
  logic        pulse_busy;
  logic [7:0]  rd_mux;

  assign wr_fall    = main_wr_l & ~main_wr;
  assign rd_fall    = main_rd_l & ~main_rd;
  assign commit     = mcu_wr & (mcu_addr == 2'd1);
  assign clr_wr     = mcu_wr & (mcu_addr == 2'd2);
  assign rd_hi      = mcu_rd & (mcu_addr == 2'd1);
  assign rd_st      = mcu_rd & (mcu_addr == 2'd2);
  assign pulse_busy = (st != IDLE);
  assign sec2       = (st == HIGH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_wr_l <= 1'b0;
      main_rd_l <= 1'b0;
    end else begin
      main_wr_l <= main_wr;
      main_rd_l <= main_rd;
    end
  end

  // Command side: a new main write always wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd      <= 16'h0;
      cmd_pend <= 1'b0;
      ovr      <= 1'b0;
      mcu_intn <= 1'b1;
    end else begin
      mcu_intn <= ~cmd_pend;
      if (wr_fall) begin
        cmd      <= main_cmd;
        cmd_pend <= 1'b1;
      end else if (rd_hi || clr_wr) begin
        cmd_pend <= 1'b0;
      end
      if (wr_fall && cmd_pend) ovr <= 1'b1;
      else if (rd_st)          ovr <= 1'b0;
    end
  end

  // Response side: mcu_dout only changes on the high-byte commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_lo   <= 8'h0;
      mcu_dout  <= 16'h0;
      resp_pend <= 1'b0;
    end else begin
      if (mcu_wr && mcu_addr == 2'd0) resp_lo <= mcu_wdata;
      if (commit) begin
        mcu_dout  <= {mcu_wdata, resp_lo};
        resp_pend <= 1'b1;
      end else if (rd_fall) begin
        resp_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = 8'hFF;
    case (mcu_addr)
      2'd0:    rd_mux = cmd[7:0];
      2'd1:    rd_mux = cmd[15:8];
      2'd2:    rd_mux = {4'b0, pulse_busy, ovr, resp_pend, cmd_pend};
      default: rd_mux = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mcu_rdata <= 8'h0;
    else if (mcu_rd) mcu_rdata <= rd_mux;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= 8'h0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // A commit during HIGH inserts one low cycle so the main CPU sees a fresh edge.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      IDLE: if (commit) begin
        st_nxt  = HIGH;
        cnt_nxt = RELOAD;
      end
      HIGH: begin
        if (commit)          st_nxt = GAP;
        else if (cnt == 8'h0) st_nxt = IDLE;
        else                 cnt_nxt = cnt - 8'd1;
      end
      GAP: begin
        st_nxt  = HIGH;
        cnt_nxt = RELOAD;
      end
      default: st_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
// Self-checking bench for jtcop_mcu_bridge: directed scenarios plus a randomized
// transaction run checked against a mailbox-level reference model.
module tb_jtcop_mcu_bridge;

  logic        rst, clk;
  logic [15:0] main_cmd;
  logic        main_wr, main_rd;
  logic [15:0] mcu_dout;
  logic        sec2;
  logic [1:0]  mcu_addr;
  logic        mcu_wr, mcu_rd;
  logic [7:0]  mcu_wdata;
  logic [7:0]  mcu_rdata;
  logic        mcu_intn;

  int n_cmp = 0;
  int n_bad = 0;

  jtcop_mcu_bridge #(.PULSE_LEN(8)) dut (
    .rst(rst), .clk(clk), .main_cmd(main_cmd), .main_wr(main_wr), .main_rd(main_rd),
    .mcu_dout(mcu_dout), .sec2(sec2), .mcu_addr(mcu_addr), .mcu_wr(mcu_wr),
    .mcu_rd(mcu_rd), .mcu_wdata(mcu_wdata), .mcu_rdata(mcu_rdata), .mcu_intn(mcu_intn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mcu_read(input logic [1:0] a, output logic [7:0] d);
    mcu_addr = a; mcu_rd = 1'b1;
    tick();
    mcu_rd = 1'b0;
    d = mcu_rdata;
  endtask

  task automatic mcu_write(input logic [1:0] a, input logic [7:0] d);
    mcu_addr = a; mcu_wdata = d; mcu_wr = 1'b1;
    tick();
    mcu_wr = 1'b0;
  endtask

  // Ends two edges after main_wr falls, so mcu_intn has settled.
  task automatic main_write(input logic [15:0] v);
    main_cmd = v; main_wr = 1'b1;
    repeat (6) tick();
    main_wr = 1'b0;
    repeat (2) tick();
  endtask

  task automatic main_read();
    main_rd = 1'b1;
    repeat (3) tick();
    main_rd = 1'b0;
    tick();
  endtask

  task automatic count_highs(input int window, output int hc);
    hc = 0;
    for (int i = 0; i < window; i++) begin
      if (sec2) hc++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; main_cmd = 16'h0; main_wr = 1'b0; main_rd = 1'b0;
    mcu_addr = 2'd0; mcu_wr = 1'b0; mcu_rd = 1'b0; mcu_wdata = 8'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    n_cmp++; if (mcu_dout !== 16'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0000", mcu_dout); end
    n_cmp++; if (sec2 !== 1'b0) begin n_bad++; $display("FAIL reset_sec2: got %b want 0", sec2); end
    n_cmp++; if (mcu_rdata !== 8'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", mcu_rdata); end
    n_cmp++; if (mcu_intn !== 1'b1) begin n_bad++; $display("FAIL reset_intn: got %b want 1", mcu_intn); end
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %h want 00", d); end
  endtask

  task automatic test_cmd_capture();
    logic [7:0] d;
    main_cmd = 16'hA55A; main_wr = 1'b1;
    repeat (6) tick();
    main_wr = 1'b0;
    tick();
    n_cmp++; if (mcu_intn !== 1'b1) begin n_bad++; $display("FAIL cap_intn_1cyc: got %b want 1", mcu_intn); end
    tick();
    n_cmp++; if (mcu_intn !== 1'b0) begin n_bad++; $display("FAIL cap_intn_2cyc: got %b want 0", mcu_intn); end
    mcu_read(2'd0, d);
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL cap_lo: got %h want 5a", d); end
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL cap_status: got %h want 01", d); end
    mcu_read(2'd1, d);
    n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL cap_hi: got %h want a5", d); end
    n_cmp++; if (mcu_intn !== 1'b0) begin n_bad++; $display("FAIL cap_intn_hold: got %b want 0", mcu_intn); end
    tick();
    n_cmp++; if (mcu_intn !== 1'b1) begin n_bad++; $display("FAIL cap_intn_clr: got %b want 1", mcu_intn); end
  endtask

  task automatic test_response();
    logic [7:0] d;
    int hc;
    mcu_write(2'd0, 8'h34);
    n_cmp++; if (sec2 !== 1'b0) begin n_bad++; $display("FAIL resp_early_sec2: got %b want 0", sec2); end
    mcu_write(2'd1, 8'h12);
    n_cmp++; if (mcu_dout !== 16'h1234) begin n_bad++; $display("FAIL resp_dout: got %h want 1234", mcu_dout); end
    count_highs(20, hc);
    n_cmp++; if (hc !== 8) begin n_bad++; $display("FAIL resp_pulse_len: got %0d want 8", hc); end
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL resp_status_pend: got %h want 02", d); end
    main_read();
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL resp_status_clr: got %h want 00", d); end
  endtask

  task automatic test_atomicity();
    int hc;
    mcu_write(2'd0, 8'h77);
    count_highs(12, hc);
    n_cmp++; if (hc !== 0) begin n_bad++; $display("FAIL atom_sec2: got %0d highs want 0", hc); end
    n_cmp++; if (mcu_dout !== 16'h1234) begin n_bad++; $display("FAIL atom_dout: got %h want 1234", mcu_dout); end
  endtask

  task automatic test_retrigger();
    logic [12:0] tr, ex;
    mcu_write(2'd0, 8'h34);
    mcu_write(2'd1, 8'h12);
    tr[0] = sec2;
    tick();                tr[1] = sec2;
    mcu_write(2'd0, 8'h78); tr[2] = sec2;
    mcu_write(2'd1, 8'h56); tr[3] = sec2;
    for (int i = 4; i < 13; i++) begin
      tick();
      tr[i] = sec2;
    end
    for (int i = 0; i < 13; i++) ex[i] = (i < 3) || (i >= 4 && i < 12);
    n_cmp++; if (tr !== ex) begin n_bad++; $display("FAIL retrig_seq: got %b want %b (bit0 first)", tr, ex); end
    n_cmp++; if (mcu_dout !== 16'h5678) begin n_bad++; $display("FAIL retrig_dout: got %h want 5678", mcu_dout); end
    main_read();
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    main_write(16'h1111);
    main_write(16'h2222);
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h05) begin n_bad++; $display("FAIL ovr_status: got %h want 05", d); end
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL ovr_status_clr: got %h want 01", d); end
    mcu_read(2'd0, d);
    n_cmp++; if (d !== 8'h22) begin n_bad++; $display("FAIL ovr_newcmd: got %h want 22", d); end
    mcu_read(2'd1, d);
  endtask

  task automatic test_collision();
    logic [7:0] d;
    main_write(16'h3333);
    main_cmd = 16'h4444; main_wr = 1'b1;
    repeat (6) tick();
    main_wr = 1'b0; mcu_addr = 2'd1; mcu_rd = 1'b1;
    tick();
    mcu_rd = 1'b0;
    n_cmp++; if (mcu_rdata !== 8'h33) begin n_bad++; $display("FAIL coll_oldhi: got %h want 33", mcu_rdata); end
    tick();
    n_cmp++; if (mcu_intn !== 1'b0) begin n_bad++; $display("FAIL coll_intn: got %b want 0", mcu_intn); end
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h05) begin n_bad++; $display("FAIL coll_status: got %h want 05", d); end
    mcu_read(2'd0, d);
    n_cmp++; if (d !== 8'h44) begin n_bad++; $display("FAIL coll_newlo: got %h want 44", d); end
    mcu_read(2'd1, d);
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL coll_status_clr: got %h want 00", d); end
    // overrun landing on a status read: the read sees the old flags, ovr stays set
    main_write(16'h5555);
    main_cmd = 16'h6666; main_wr = 1'b1;
    repeat (6) tick();
    main_wr = 1'b0; mcu_addr = 2'd2; mcu_rd = 1'b1;
    tick();
    mcu_rd = 1'b0;
    n_cmp++; if (mcu_rdata !== 8'h01) begin n_bad++; $display("FAIL ovrst_read: got %h want 01", mcu_rdata); end
    mcu_read(2'd2, d);
    n_cmp++; if (d !== 8'h05) begin n_bad++; $display("FAIL ovrst_kept: got %h want 05", d); end
    mcu_read(2'd1, d);
  endtask

  task automatic test_random();
    logic [15:0] m_cmd = 16'h6666, m_dout = 16'h5678, v;
    logic [7:0]  m_lo = 8'h78, d, e;
    logic        m_pend = 1'b0, m_ovr = 1'b0, m_rpend = 1'b0;
    logic [1:0]  a;
    int hc;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: begin
          v = 16'($urandom);
          if (m_pend) m_ovr = 1'b1;
          m_cmd = v; m_pend = 1'b1;
          main_write(v);
        end
        1: begin
          a = 2'($urandom_range(0, 3));
          case (a)
            2'd0: e = m_cmd[7:0];
            2'd1: e = m_cmd[15:8];
            2'd2: e = {5'b0, m_ovr, m_rpend, m_pend};
            default: e = 8'hFF;
          endcase
          if (a == 2'd1) m_pend = 1'b0;
          if (a == 2'd2) m_ovr = 1'b0;
          mcu_read(a, d);
          n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rnd_read[%0d] addr %0d: got %h want %h", n, a, d, e); end
        end
        2: begin
          d = 8'($urandom);
          m_lo = d;
          mcu_write(2'd0, d);
        end
        3: begin
          d = 8'($urandom);
          m_dout = {d, m_lo}; m_rpend = 1'b1;
          mcu_write(2'd1, d);
          count_highs(14, hc);
          n_cmp++; if (hc !== 8) begin n_bad++; $display("FAIL rnd_pulse[%0d]: got %0d want 8", n, hc); end
        end
        4: begin
          a = $urandom_range(0, 1) ? 2'd2 : 2'd3;
          if (a == 2'd2) m_pend = 1'b0;
          mcu_write(a, 8'($urandom));
        end
        default: begin
          m_rpend = 1'b0;
          main_read();
        end
      endcase
      tick();
      n_cmp++; if (mcu_intn !== ~m_pend) begin n_bad++; $display("FAIL rnd_intn[%0d]: got %b want %b", n, mcu_intn, ~m_pend); end
      n_cmp++; if (mcu_dout !== m_dout) begin n_bad++; $display("FAIL rnd_dout[%0d]: got %h want %h", n, mcu_dout, m_dout); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int hc;
    main_write(16'h9999);
    mcu_write(2'd0, 8'hEF);
    mcu_write(2'd1, 8'hBE);
    repeat (3) tick();
    n_cmp++; if (sec2 !== 1'b1) begin n_bad++; $display("FAIL rstp_inpulse: got %b want 1", sec2); end
    rst = 1'b1;
    #1;
    n_cmp++; if (sec2 !== 1'b0) begin n_bad++; $display("FAIL rstp_sec2: got %b want 0", sec2); end
    n_cmp++; if (mcu_intn !== 1'b1) begin n_bad++; $display("FAIL rstp_intn: got %b want 1", mcu_intn); end
    n_cmp++; if (mcu_dout !== 16'h0) begin n_bad++; $display("FAIL rstp_dout: got %h want 0000", mcu_dout); end
    repeat (2) tick();
    rst = 1'b0;
    count_highs(15, hc);
    n_cmp++; if (hc !== 0) begin n_bad++; $display("FAIL rstp_nopulse: got %0d highs want 0", hc); end
    n_cmp++; if (mcu_intn !== 1'b1) begin n_bad++; $display("FAIL rstp_intn_after: got %b want 1", mcu_intn); end
  endtask

  initial begin
    test_reset();
    test_cmd_capture();
    test_response();
    test_atomicity();
    test_retrigger();
    test_overrun();
    test_collision();
    test_random();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
